// File: rtl/ex_mem_bridge.sv
// rtl/ex_mem_bridge.sv - execute-stage data port to wait-stated slave bridge with PMP and timeout fault capture
module ex_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m_addr_i,
    input  logic [DATA_W-1:0] m_data_i,
    input  logic              m_req_i,
    input  logic              m_we_i,
    input  logic              m_pmp_fault_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_hold_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_req_o,
    output logic              s_we_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,
    output logic              fault_valid_o,
    output logic [1:0]        fault_cause_o,
    output logic [ADDR_W-1:0] fault_addr_o,
    output logic              fault_we_o,
    input  logic              fault_clr_i
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       cnt;
    logic [DATA_W-1:0] rdata;
    logic              issue, pmp_evt, to_evt, ack_evt;
    logic              fault_evt;
    logic [1:0]        fault_cause_nxt;
    logic [ADDR_W-1:0] fault_addr_nxt;
    logic              fault_we_nxt;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pmp_evt   = 1'b0;
        to_evt    = 1'b0;
        ack_evt   = 1'b0;
        m_hold_o  = 1'b0;
        m_data_o  = '0;
        case (state)
            ST_IDLE: begin
                if (m_req_i) begin
                    if (m_pmp_fault_i) begin
                        pmp_evt = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        m_hold_o  = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                m_hold_o = 1'b1;
                // An ack arriving on the last allowed cycle still completes the access.
                if (s_ack_i) begin
                    ack_evt   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == TO_LAST) begin
                    to_evt    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                m_data_o  = rdata;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fault_evt       = pmp_evt | to_evt;
    assign fault_cause_nxt = pmp_evt ? 2'b01 : 2'b10;
    assign fault_addr_nxt  = pmp_evt ? m_addr_i : s_addr_o;
    assign fault_we_nxt    = pmp_evt ? m_we_i : s_we_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rdata         <= '0;
            s_addr_o      <= '0;
            s_data_o      <= '0;
            s_req_o       <= 1'b0;
            s_we_o        <= 1'b0;
            fault_valid_o <= 1'b0;
            fault_cause_o <= 2'b00;
            fault_addr_o  <= '0;
            fault_we_o    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                s_addr_o <= m_addr_i;
                s_data_o <= m_data_i;
                s_we_o   <= m_we_i;
                s_req_o  <= 1'b1;
                cnt      <= '0;
            end else if (state == ST_WAIT) begin
                if (cnt != 16'hFFFF) begin
                    cnt <= cnt + 16'd1;
                end
                if (ack_evt || to_evt) begin
                    s_req_o <= 1'b0;
                end
                if (ack_evt) begin
                    rdata <= s_data_i;
                end else if (to_evt) begin
                    rdata <= '0;
                end
            end
            // A clear in the same cycle frees the record for the incoming fault.
            if (fault_evt && (!fault_valid_o || fault_clr_i)) begin
                fault_valid_o <= 1'b1;
                fault_cause_o <= fault_cause_nxt;
                fault_addr_o  <= fault_addr_nxt;
                fault_we_o    <= fault_we_nxt;
            end else if (fault_clr_i) begin
                fault_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_bridge.sv
// tb/tb_ex_mem_bridge.sv - directed self-checking bench for ex_mem_bridge
module tb_ex_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr_i, m_data_i, m_data_o;
    logic        m_req_i, m_we_i, m_pmp_fault_i, m_hold_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_req_o, s_we_o, s_ack_i;
    logic        fault_valid_o, fault_we_o, fault_clr_i;
    logic [1:0]  fault_cause_o;
    logic [31:0] fault_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_pmp_fault_i(m_pmp_fault_i), .m_data_o(m_data_o), .m_hold_o(m_hold_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .fault_valid_o(fault_valid_o), .fault_cause_o(fault_cause_o),
        .fault_addr_o(fault_addr_o), .fault_we_o(fault_we_o), .fault_clr_i(fault_clr_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one non-faulting access; ack_at is the 1-based WAIT cycle that acks (0 = never).
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input int ack_at, input logic [31:0] rd,
                          output int holds, output int reqs, output logic [31:0] dout,
                          output logic stable);
        logic done;
        m_addr_i = a; m_data_i = d; m_we_i = we; m_req_i = 1'b1; m_pmp_fault_i = 1'b0;
        #1;
        holds = 0; reqs = 0; dout = 'x; stable = 1'b1; done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (c > 0 && !m_hold_o) begin
                dout = m_data_o;
                done = 1'b1;
            end else begin
                if (m_hold_o) holds++;
                if (s_req_o) begin
                    reqs++;
                    if (s_addr_o !== a || s_we_o !== we || (we && s_data_o !== d)) stable = 1'b0;
                    s_ack_i  = (reqs == ack_at);
                    s_data_i = rd;
                end
                step();
                s_ack_i = 1'b0;
            end
        end
        if (!done) check("access_bound", 0, 1);
        m_req_i = 1'b0;
        step();
    endtask

    int          holds, reqs;
    logic [31:0] dout;
    logic        stable;

    initial begin
        rst = 1'b1; m_addr_i = '0; m_data_i = '0; m_req_i = 1'b0; m_we_i = 1'b0;
        m_pmp_fault_i = 1'b0; s_data_i = '0; s_ack_i = 1'b0; fault_clr_i = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_s_req", s_req_o, 0);
        check("rst_s_we", s_we_o, 0);
        check("rst_hold", m_hold_o, 0);
        check("rst_s_addr", s_addr_o, 0);
        check("rst_s_data", s_data_o, 0);
        check("rst_m_data", m_data_o, 0);
        check("rst_fault", {fault_valid_o, fault_cause_o, fault_we_o, fault_addr_o}, 0);

        access(32'h8000_0010, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, holds, reqs, dout, stable);
        check("rd0_holds", holds, 2);
        check("rd0_reqs", reqs, 1);
        check("rd0_data", dout, 32'hDEAD_BEEF);
        check("rd0_stable", stable, 1);

        access(32'h1000_0004, 32'h1234_5678, 1'b1, 4, 32'h5555_AAAA, holds, reqs, dout, stable);
        check("wr3_holds", holds, 5);
        check("wr3_reqs", reqs, 4);
        check("wr3_stable", stable, 1);
        check("wr3_no_fault", fault_valid_o, 0);

        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0;
        check("idle_ack_req", s_req_o, 0);
        check("idle_ack_hold", m_hold_o, 0);

        m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h2000_0000; m_pmp_fault_i = 1'b1;
        #1;
        check("pmp_hold", m_hold_o, 0);
        check("pmp_mdata", m_data_o, 0);
        step();
        check("pmp_s_req", s_req_o, 0);
        check("pmp_valid", fault_valid_o, 1);
        check("pmp_cause", fault_cause_o, 2'b01);
        check("pmp_addr", fault_addr_o, 32'h2000_0000);
        check("pmp_we", fault_we_o, 1);
        m_we_i = 1'b0; m_addr_i = 32'h3000_0000;
        step();
        check("pmp2_addr", fault_addr_o, 32'h2000_0000);
        check("pmp2_we", fault_we_o, 1);
        check("pmp2_s_req", s_req_o, 0);
        m_req_i = 1'b0; m_pmp_fault_i = 1'b0;

        fault_clr_i = 1'b1;
        step();
        fault_clr_i = 1'b0;
        check("clr_valid", fault_valid_o, 0);

        access(32'h9000_0020, 32'h0, 1'b0, 4, 32'hCAFE_F00D, holds, reqs, dout, stable);
        check("edge_ack_data", dout, 32'hCAFE_F00D);
        check("edge_ack_no_fault", fault_valid_o, 0);

        access(32'h5000_0000, 32'h0, 1'b0, 0, 32'hFFFF_FFFF, holds, reqs, dout, stable);
        check("to_holds", holds, 5);
        check("to_reqs", reqs, 4);
        check("to_data", dout, 0);
        check("to_valid", fault_valid_o, 1);
        check("to_cause", fault_cause_o, 2'b10);
        check("to_addr", fault_addr_o, 32'h5000_0000);
        check("to_we", fault_we_o, 0);

        fault_clr_i = 1'b1; m_req_i = 1'b1; m_pmp_fault_i = 1'b1;
        m_addr_i = 32'h4000_0000; m_we_i = 1'b0;
        step();
        fault_clr_i = 1'b0; m_req_i = 1'b0; m_pmp_fault_i = 1'b0;
        check("clrpmp_valid", fault_valid_o, 1);
        check("clrpmp_addr", fault_addr_o, 32'h4000_0000);
        check("clrpmp_cause", fault_cause_o, 2'b01);

        m_req_i = 1'b1; m_addr_i = 32'h6000_0000; m_we_i = 1'b0;
        step();
        step();
        check("rstw_in_wait", s_req_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; m_req_i = 1'b0;
        #1;
        check("rstw_s_req", s_req_o, 0);
        check("rstw_hold", m_hold_o, 0);
        check("rstw_fault", {fault_valid_o, fault_cause_o, fault_we_o, fault_addr_o}, 0);
        step();
        check("rstw_idle_hold", m_hold_o, 0);

        access(32'h7000_0000, 32'h0, 1'b0, 2, 32'h0BAD_C0DE, holds, reqs, dout, stable);
        check("post_rst_holds", holds, 3);
        check("post_rst_data", dout, 32'h0BAD_C0DE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_bridge.md
# ex_mem_bridge

Registered bridge between the core's execute-stage data port (`rib_ex_*`) and a wait-stated bus slave.
- Converts the core's single-cycle combinational load/store into a req/ack transaction and stalls the core through its hold input while the access is outstanding.
- Drops accesses flagged by the PMP checker and records the first faulting access.
- Aborts accesses that time out without an acknowledge.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYCLES`, 255: number of WAIT cycles without `s_ack_i` before the access is aborted. Must be 1..65535.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `m_addr_i` in ADDR_W: core access address.
- `m_data_i` in DATA_W: core write data.
- `m_req_i` in 1: core access request.
- `m_we_i` in 1: core write enable.
- `m_pmp_fault_i` in 1: PMP exception for the current `m_addr_i`/`m_we_i`.
- `m_data_o` out DATA_W: read data returned to the core.
- `m_hold_o` out 1: stall request into the core's `rib_hold_flag_i`.
- `s_addr_o` out ADDR_W: registered slave address.
- `s_data_o` out DATA_W: registered slave write data.
- `s_req_o` out 1: registered slave request.
- `s_we_o` out 1: registered slave write enable.
- `s_data_i` in DATA_W: slave read data.
- `s_ack_i` in 1: single-cycle slave acknowledge.
- `fault_valid_o` out 1: sticky flag, a fault has been captured.
- `fault_cause_o` out 2: 01 = PMP, 10 = timeout.
- `fault_addr_o` out ADDR_W: address of the captured fault.
- `fault_we_o` out 1: the captured faulting access was a write.
- `fault_clr_i` in 1: clears the fault record.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset enters IDLE.
- **IDLE, `m_req_i`=1, `m_pmp_fault_i`=0:**
  - Register `m_addr_i`, `m_data_i`, `m_we_i` into `s_addr_o`, `s_data_o`, `s_we_o`.
  - Set `s_req_o`=1 and clear the timeout counter.
  - Go to WAIT.
  - `m_hold_o`=1 in this cycle.
- **IDLE, `m_req_i`=1, `m_pmp_fault_i`=1:**
  - No slave access is issued; a write is discarded.
  - `m_hold_o`=0 and `m_data_o`=0.
  - If `fault_valid_o`=0, capture cause=01, the address, and `m_we_i`.
  - Stay in IDLE.
- **IDLE, `m_req_i`=0:** `m_hold_o`=0 and `m_data_o`=0.
- **WAIT:**
  - `m_hold_o`=1 and `s_req_o` stays 1 with stable address/data/we.
  - Counter increments by 1 each cycle and saturates.
  - `s_ack_i`=1: capture `s_data_i` into the read-data register (also on writes; value ignored by the core), drop `s_req_o`, go to DONE.
  - Counter == TIMEOUT_CYCLES-1 with no ack: drop `s_req_o`, read-data register = 0, capture a timeout fault (cause=10) if none is held, go to DONE.
  - Ack in the same cycle as the timeout: ack wins and no fault is recorded.
- **DONE:** `m_hold_o`=0 and `m_data_o` = read-data register, so the core consumes the result at the clock edge. Go to IDLE unconditionally.
- **Fault record:**
  - Only the first fault is kept; later faults are ignored while `fault_valid_o`=1.
  - `fault_clr_i` clears `fault_valid_o` next cycle.
  - If a new fault and `fault_clr_i` occur in the same cycle, the new fault is captured and `fault_valid_o` stays 1.
- **`m_data_o`:** combinational from the state. Read-data register in DONE, 0 otherwise.

## Timing
- Reset values:
  - `s_req_o`, `s_we_o`, `m_hold_o`: 0.
  - `s_addr_o`, `s_data_o`, `m_data_o`: 0.
  - `fault_valid_o`, `fault_cause_o`, `fault_addr_o`, `fault_we_o`: 0.
  - FSM in IDLE, counter 0.
- `m_hold_o` is combinational: (IDLE & `m_req_i` & ~`m_pmp_fault_i`) | WAIT.
- Minimum transaction, ack in the first WAIT cycle:
  - Cycle 0: IDLE, hold=1.
  - Cycle 1: WAIT, `s_req_o`=1, ack.
  - Cycle 2: DONE, data valid, hold=0.
  - The core is stalled 2 cycles.
- Each extra wait-state adds 1 stall cycle.
- A timeout reaches DONE TIMEOUT_CYCLES cycles after entering WAIT.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE; no bubble beyond DONE.
- `s_ack_i` is sampled only in WAIT; an ack in IDLE or DONE is ignored.
- Reset mid-transaction:
  - Drops `s_req_o` at the next edge and abandons the access.
  - The slave must tolerate a withdrawn request.

## Test plan
- **Read, 0 wait-states:** read 0x8000_0010, slave acks in the first WAIT cycle with 0xDEAD_BEEF -> `m_hold_o`=1 for 2 cycles; DONE shows `m_data_o`=0xDEAD_BEEF; `s_req_o` high for exactly 1 cycle.
- **Write, 3 wait-states:** write 0x1234_5678 to 0x1000_0004, ack on the 4th WAIT cycle -> `s_we_o`=1, `s_addr_o`/`s_data_o` stable through WAIT; hold for 5 cycles; no fault.
- **PMP fault:** write to 0x2000_0000 with `m_pmp_fault_i`=1 -> `s_req_o` never rises, hold=0, `fault_valid_o`=1, cause=01, `fault_addr_o`=0x2000_0000, `fault_we_o`=1. A second fault to 0x3000_0000 leaves the record unchanged.
- **Timeout, TIMEOUT_CYCLES=4, no ack:**
  - Read -> DONE after 4 WAIT cycles with `m_data_o`=0 and cause=10.
  - Ack on the 4th WAIT cycle -> data returned, no fault.
- **Fault clear:** `fault_clr_i` alone -> `fault_valid_o`=0 next cycle. `fault_clr_i` with a simultaneous PMP fault at 0x4000_0000 -> `fault_valid_o` stays 1, address 0x4000_0000.
- **Reset mid-WAIT:** assert `rst` on the 2nd WAIT cycle -> next cycle `s_req_o`=0, `m_hold_o`=0, FSM in IDLE, fault record 0; a subsequent read completes normally.
